// File: rtl/reg_read_stage.sv
// reg_read_stage: two-entry operand read buffer with write-back forwarding and snoop
module reg_read_stage #(
  parameter int DATA_W = 16,
  parameter int NREG = 16,
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREG*DATA_W-1:0] reg_flat,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic [NREG-1:0]        wb_enable,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_src,
  input  logic [ADDR_W-1:0]      req_dst,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_src,
  output logic [DATA_W-1:0]      out_dst,
  output logic [ADDR_W-1:0]      out_src_a,
  output logic [ADDR_W-1:0]      out_dst_a
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] sa;
    logic [ADDR_W-1:0] da;
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] d;
  } entry_t;
  state_t state, state_n;
  entry_t main, main_n, skid, skid_n, req_e, main_sn, skid_sn;
  logic [DATA_W-1:0] r [NREG];
  logic accept, consume;
  for (genvar i = 0; i < NREG; i++) begin : g_bank
    assign r[i] = reg_flat[i*DATA_W +: DATA_W];
  end
  assign req_ready = state != TWO;
  assign out_valid = state != EMPTY;
  assign accept = req_valid && req_ready;
  assign consume = out_valid && out_ready;
  assign req_e = '{sa: req_src, da: req_dst,
                   s: wb_enable[req_src] ? wb_data : r[req_src],
                   d: wb_enable[req_dst] ? wb_data : r[req_dst]};
  assign main_sn = '{sa: main.sa, da: main.da,
                     s: wb_enable[main.sa] ? wb_data : main.s,
                     d: wb_enable[main.da] ? wb_data : main.d};
  assign skid_sn = '{sa: skid.sa, da: skid.da,
                     s: wb_enable[skid.sa] ? wb_data : skid.s,
                     d: wb_enable[skid.da] ? wb_data : skid.d};
  always_comb begin
    state_n = state;
    main_n = main;
    skid_n = skid;
    case (state)
      EMPTY: begin
        main_n = accept ? req_e : main;
        state_n = accept ? ONE : EMPTY;
      end
      ONE: begin
        main_n = (accept && consume) ? req_e : main_sn;
        skid_n = accept ? req_e : skid;
        state_n = (accept && !consume) ? TWO : (!accept && consume) ? EMPTY : ONE;
      end
      TWO: begin
        main_n = consume ? skid_sn : main_sn;
        skid_n = skid_sn;
        state_n = consume ? ONE : TWO;
      end
      default: state_n = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      main <= '0;
      skid <= '0;
    end else begin
      state <= state_n;
      main <= main_n;
      skid <= skid_n;
    end
  end
  assign out_src = main.s;
  assign out_dst = main.d;
  assign out_src_a = main.sa;
  assign out_dst_a = main.da;
endmodule
